lstm_gate_sequencer: RTL and testbench
======================================

# lstm_gate_sequencer

Upstream feeder for the LSTM gate-operand 4:1 multiplexer. Accepts one set of four gate operands (input, forget, cell-candidate, output) per valid/ready transfer and buffers up to two sets in a ping-pong bank. It presents the oldest set on d0..d3 and steps sel through gates 0→3 under downstream flow control, driving en only while a set is being streamed. Sits between the gate pre-activation producer and the gate mux / activation path.

## Interface
- WIDTH, 64, bit width of each gate operand (matches mux data width)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all buffered sets and in-progress stream
- in_valid  in  1  upstream set valid
- in_ready  out  1  block can accept a set
- in_gi, in_gf, in_gg, in_go  in  WIDTH each  gate operands i, f, g, o
- d0, d1, d2, d3  out  WIDTH each  operands of the set at the bank head, to mux
- sel  out  2  gate index to mux
- en  out  1  mux enable; equals out_valid
- out_valid  out  1  mux output is a valid gate operand
- out_ready  in  1  downstream consumes current gate
- out_last  out  1  current gate is the last (o) of its set

## Operation
- Bank: 2 slots × 4×WIDTH; wr_ptr, rd_ptr (1 bit each), count (0..2).
- in_ready = (count != 2) and not flush; registered state only, no combinational path from out_ready.
- Accept when in_valid & in_ready: slot[wr_ptr] ← {gi,gf,gg,go}, wr_ptr toggles, count +1.
- d0..d3 = slot[rd_ptr] (gi,gf,gg,go); forced to zero when count == 0.
- States: IDLE (count == 0: en=0, out_valid=0, sel=0); STREAM (count > 0: en=1, out_valid=1).
- Gate step on out_valid & out_ready: sel < 3 → sel+1; sel == 3 → sel ← 0, rd_ptr toggles, count −1.
- out_last = out_valid & (sel == 3).
- Accept and set-release in the same cycle: count unchanged, both pointers move.
- Downstream stall (out_ready low): sel, d0..d3, en held stable.
- flush: count, sel, pointers ← 0; outputs go to reset values next cycle; an in_valid in the flush cycle is not accepted.
- Priority: rst > flush > handshakes.

## Timing
- Reset values: in_ready=1 (after the reset cycle), d0..d3=0, sel=0, en=0, out_valid=0, out_last=0.
- Accepted set visible on d0..d3 with en=1, sel=0 the cycle after acceptance (1-cycle latency) when the bank was empty.
- With continuous out_ready, one set streams in exactly 4 cycles; back-to-back sets stream with no bubble.
- Sustained throughput: one set per 4 cycles; in_ready drops only when both slots are occupied.
- Reset or flush mid-stream: partial set discarded, no further gates emitted for it.

## Structure
- Package lstm_seq_pkg: GATE_I=2'd0, GATE_F=2'd1, GATE_G=2'd2, GATE_O=2'd3, NUM_GATES=4, gate-index typedef.
- Sub-module lstm_gate_bank: 2-slot register file with write port (wr_ptr, data, we) and read port (rd_ptr). Pointers, count and sel control stay in the top module.

## Test plan
- Single set: accept gi=0x1, gf=0x2, gg=0x3, go=0x4 with out_ready=1 → next 4 cycles sel=0,1,2,3, en=1, out_last only at sel=3, then en=0 and d0..d3=0.
- Fill: three consecutive in_valid with out_ready=0 → first two accepted, in_ready=0 on the third, sel held at 0, d0 = first set's gi.
- Simultaneous: count=2, sel=3, out_ready=1 and in_valid=1 in the same cycle → in_ready stays low that cycle; set released, count=1 next cycle, third set accepted the cycle after.
- Back-to-back: two sets preloaded, out_ready=1 → 8 consecutive valid gates, sel wraps 3→0 with no bubble, d0 switches to second set's gi when sel returns to 0.
- Stall: toggle out_ready 1,0,0,1 mid-set → sel advances only on out_ready=1 cycles, d0..d3 stable throughout.
- Flush/reset mid-stream: assert flush at sel=2 with count=2 → next cycle en=0, sel=0, count=0, in_ready=1; repeat with rst → identical result.

Source files
------------

// File: rtl/lstm_gate_sequencer_pkg.sv
// Shared gate indices and FSM encoding for the LSTM gate-operand sequencer.
package lstm_seq_pkg;

  localparam int NUM_GATES = 4;

  typedef logic [1:0] gate_idx_t;

  localparam gate_idx_t GATE_I = 2'd0;
  localparam gate_idx_t GATE_F = 2'd1;
  localparam gate_idx_t GATE_G = 2'd2;
  localparam gate_idx_t GATE_O = 2'd3;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } seq_state_e;

endpackage

// File: rtl/lstm_gate_bank.sv
// Two-slot ping-pong store of gate-operand sets; one write port, one read port.
module lstm_gate_bank
  import lstm_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic                                 wr_ptr,
  input  logic [NUM_GATES-1:0][WIDTH-1:0]      wr_data,
  input  logic                                 rd_ptr,
  output logic [NUM_GATES-1:0][WIDTH-1:0]      rd_data
);

  logic [NUM_GATES-1:0][WIDTH-1:0] slot_q [2];
  logic [NUM_GATES-1:0][WIDTH-1:0] slot_d [2];

  // Payload needs no reset: the top masks reads while the bank is empty.
  always_comb begin
    slot_d = slot_q;
    if (we) slot_d[wr_ptr] = wr_data;
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign rd_data = slot_q[rd_ptr];

endmodule

// File: rtl/lstm_gate_sequencer.sv
// Buffers up to two gate-operand sets and streams the oldest one gate by gate
// (i, f, g, o) to the gate mux under valid/ready flow control.
module lstm_gate_sequencer
  import lstm_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gi,
  input  logic [WIDTH-1:0] in_gf,
  input  logic [WIDTH-1:0] in_gg,
  input  logic [WIDTH-1:0] in_go,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [1:0]       sel,
  output logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  seq_state_e state_q, state_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  gate_idx_t  sel_q, sel_d;

  logic accept, step, release_set;
  logic [NUM_GATES-1:0][WIDTH-1:0] wr_data, rd_data;

  assign wr_data = {in_go, in_gg, in_gf, in_gi};

  lstm_gate_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .we      (accept),
    .wr_ptr  (wr_ptr_q),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sel_d       = sel_q;
    out_valid   = (state_q == S_STREAM);
    en          = out_valid;
    out_last    = out_valid && (sel_q == GATE_O);
    in_ready    = (count_q != 2'd2) && !flush;
    accept      = in_valid && in_ready;
    step        = out_valid && out_ready;
    release_set = step && (sel_q == GATE_O);

    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      sel_d    = GATE_I;
    end else begin
      if (step) sel_d = release_set ? GATE_I : gate_idx_t'(sel_q + 2'd1);
      if (release_set) rd_ptr_d = ~rd_ptr_q;
      if (accept) wr_ptr_d = ~wr_ptr_q;
      // Accept and release in one cycle cancel out on count.
      count_d = count_q + {1'b0, accept} - {1'b0, release_set};
    end

    state_d = (count_d != 2'd0) ? S_STREAM : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      sel_q    <= GATE_I;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sel_q    <= sel_d;
    end
  end

  assign sel = sel_q;
  assign d0  = out_valid ? rd_data[0] : '0;
  assign d1  = out_valid ? rd_data[1] : '0;
  assign d2  = out_valid ? rd_data[2] : '0;
  assign d3  = out_valid ? rd_data[3] : '0;

endmodule

// File: tb/tb_lstm_gate_sequencer.sv
// Scoreboard bench: each accepted set expands into four expected gate beats;
// a negedge monitor compares the DUT against the head beat and pops on consume.
module tb_lstm_gate_sequencer;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_gi = '0, in_gf = '0, in_gg = '0, in_go = '0;
  logic in_ready, en, out_valid, out_last;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0] sel;

  lstm_gate_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_gi(in_gi), .in_gf(in_gf), .in_gg(in_gg), .in_go(in_go),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .sel(sel), .en(en),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]          sel;
    logic                last;
    logic [3:0][W-1:0]   d;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;
  bit pend = 1'b0;
  logic [3:0][W-1:0] pend_d;

  function automatic int sets_held();
    return (exp_q.size() + 3) / 4;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: inputs and outputs are both stable at the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, (sets_held() < 2) && !flush);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("en", en, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("sel", sel, exp_q[0].sel);
        chk("out_last", out_last, exp_q[0].last);
        chk("d0", d0, exp_q[0].d[0]);
        chk("d1", d1, exp_q[0].d[1]);
        chk("d2", d2, exp_q[0].d[2]);
        chk("d3", d3, exp_q[0].d[3]);
      end else begin
        chk("idle_sel", sel, 0);
        chk("idle_last", out_last, 0);
        chk("idle_d", d0 | d1 | d2 | d3, 0);
      end
      if (rst || flush) exp_q.delete();
      else if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    end
  end

  function automatic logic [3:0][W-1:0] rand_set();
    logic [3:0][W-1:0] s;
    for (int g = 0; g < 4; g++) s[g] = {$urandom, $urandom};
    return s;
  endfunction

  // One cycle of stimulus, driven just after the rising edge.
  task automatic cyc(input bit iv, input bit ordy, input bit fl, input bit rs,
                     input logic [3:0][W-1:0] data);
    @(posedge clk);
    #1;
    if (pend) begin
      for (int g = 0; g < 4; g++) begin
        beat_t b;
        b.sel  = 2'(g);
        b.last = (g == 3);
        b.d    = pend_d;
        exp_q.push_back(b);
      end
    end
    rst = rs; flush = fl; in_valid = iv; out_ready = ordy;
    in_gi = data[0]; in_gf = data[1]; in_gg = data[2]; in_go = data[3];
    pend   = iv && !fl && !rs && (sets_held() < 2);
    pend_d = data;
  endtask

  initial begin
    logic [3:0][W-1:0] s1;
    int pr;
    s1 = {64'd4, 64'd3, 64'd2, 64'd1};

    cyc(0, 0, 0, 1, rand_set());
    cyc(0, 0, 0, 1, rand_set());
    mon_en = 1'b1;
    cyc(0, 0, 0, 0, rand_set());

    // single set, free-running downstream
    cyc(1, 1, 0, 0, s1);
    repeat (6) cyc(0, 1, 0, 0, rand_set());

    // fill with downstream stalled, then release while a new set is offered
    repeat (3) cyc(1, 0, 0, 0, rand_set());
    repeat (2) cyc(0, 0, 0, 0, rand_set());
    repeat (3) cyc(0, 1, 0, 0, rand_set());
    repeat (2) cyc(1, 1, 0, 0, rand_set());
    // stall pattern mid-set
    cyc(0, 1, 0, 0, rand_set());
    cyc(0, 0, 0, 0, rand_set());
    cyc(0, 0, 0, 0, rand_set());
    cyc(0, 1, 0, 0, rand_set());
    repeat (12) cyc(0, 1, 0, 0, rand_set());

    // flush and reset at sel=2 with two sets buffered
    for (int k = 0; k < 2; k++) begin
      repeat (2) cyc(1, 0, 0, 0, rand_set());
      repeat (2) cyc(0, 1, 0, 0, rand_set());
      cyc(1, 0, k == 0, k == 1, rand_set());
      repeat (2) cyc(0, 0, 0, 0, rand_set());
    end

    // randomized traffic with varying downstream pressure
    pr = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) pr = $urandom_range(0, 4) * 25;
      cyc($urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < pr,
          $urandom_range(0, 63) == 0,
          $urandom_range(0, 299) == 0,
          rand_set());
    end

    repeat (12) cyc(0, 1, 0, 0, rand_set());
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
